// File: rtl/lz77_code_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : lz77_code_scheduler
// Purpose  : Buffers LZ77 codewords (pos, len, next-char) in a small FIFO and
//            replays each one on the decoder inputs for len+1 back-to-back
//            steps, strobing dec_step once per decoded character. It counts
//            the characters it emits and stops at the END_CHAR literal.
// Options  : LZ_CHECK_EN - when defined, flags copy codewords whose position
//            is outside the search buffer or not yet decoded (sticky err).
//            When undefined, err is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module lz77_code_scheduler #(
    parameter int          FIFO_DEPTH = 4,
    parameter int          SEARCH_LEN = 9,
    parameter logic [7:0]  END_CHAR   = 8'h24
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cw_valid,
    output logic        cw_ready,
    input  logic [3:0]  cw_pos,
    input  logic [2:0]  cw_len,
    input  logic [7:0]  cw_char,
    output logic        dec_step,
    output logic [3:0]  code_pos,
    output logic [2:0]  code_len,
    output logic [7:0]  chardata,
    output logic        done,
    output logic [15:0] out_cnt,
    output logic        err
);

    localparam int              AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int              CW       = AW + 1;
    localparam logic [CW-1:0]   FULL_CNT = CW'(FIFO_DEPTH);

    // Reject configurations the pointer arithmetic cannot handle.
    generate
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
            SEARCH_LEN < 1 || SEARCH_LEN > 16) begin : g_bad_params
            $error("lz77_code_scheduler: unsupported FIFO_DEPTH/SEARCH_LEN");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Codeword storage, packed as {pos, len, char}.
    logic [14:0]    mem_q [FIFO_DEPTH];

    state_t         state_q,    state_d;
    logic [AW-1:0]  rd_ptr_q,   rd_ptr_d;
    logic [AW-1:0]  wr_ptr_q,   wr_ptr_d;
    logic [CW-1:0]  count_q,    count_d;
    logic [3:0]     k_q,        k_d;
    logic           dec_step_q, dec_step_d;
    logic [3:0]     code_pos_q, code_pos_d;
    logic [2:0]     code_len_q, code_len_d;
    logic [7:0]     chardata_q, chardata_d;
    logic           done_q,     done_d;
    logic [15:0]    out_cnt_q,  out_cnt_d;

    logic           w_full;
    logic           w_push;
    logic           w_final_step;
    logic           w_end_hit;
    logic [CW-1:0]  w_cnt_after;
    logic [AW-1:0]  w_rd_after;
    logic [14:0]    w_cand;
    logic           w_start_new;

    // Readiness depends only on registered state: no push-through when full.
    assign w_full   = (count_q == FULL_CNT);
    assign cw_ready = !w_full && (state_q != ST_DONE);
    assign w_push   = cw_valid && cw_ready;

    // The head is retired on the step whose index equals its length.
    assign w_final_step = (state_q == ST_ISSUE) && (k_q == {1'b0, code_len_q});
    assign w_end_hit    = w_final_step && (chardata_q == END_CHAR);

    // Next codeword candidate: stored entry behind the head if one exists,
    // otherwise the word arriving this cycle (empty-FIFO bypass keeps the
    // push-to-first-step latency at one cycle).
    assign w_cnt_after = count_q - CW'(w_final_step);
    assign w_rd_after  = rd_ptr_q + AW'(w_final_step);
    assign w_cand      = (w_cnt_after != '0) ? mem_q[w_rd_after]
                                             : {cw_pos, cw_len, cw_char};
    assign w_start_new = ((state_q == ST_IDLE) || (w_final_step && !w_end_hit)) &&
                         ((w_cnt_after != '0) || w_push);

    // FIFO storage write; contents need no reset since count gates reads.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= {cw_pos, cw_len, cw_char};
        end
    end

    // Next-state: FIFO bookkeeping, step sequencing and decoder outputs.
    always_comb begin
        state_d    = state_q;
        rd_ptr_d   = w_rd_after;
        wr_ptr_d   = w_push ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
        count_d    = w_cnt_after + CW'(w_push);
        k_d        = k_q;
        dec_step_d = 1'b0;
        code_pos_d = code_pos_q;
        code_len_d = code_len_q;
        chardata_d = chardata_q;
        done_d     = done_q;

        case (state_q)
            ST_DONE: begin
                // Terminal: nothing issues, leftover entries stay discarded.
                rd_ptr_d = '0;
                wr_ptr_d = '0;
                count_d  = '0;
            end
            default: begin
                if (w_end_hit) begin
                    state_d  = ST_DONE;
                    done_d   = 1'b1;
                    rd_ptr_d = '0;
                    wr_ptr_d = '0;
                    count_d  = '0;
                end else if (w_start_new) begin
                    state_d    = ST_ISSUE;
                    dec_step_d = 1'b1;
                    k_d        = 4'd0;
                    code_pos_d = w_cand[14:11];
                    code_len_d = w_cand[10:8];
                    chardata_d = w_cand[7:0];
                end else if ((state_q == ST_ISSUE) && !w_final_step) begin
                    dec_step_d = 1'b1;
                    k_d        = k_q + 4'd1;
                end else begin
                    // Underflow: hold the decoder inputs, stop strobing.
                    state_d = ST_IDLE;
                end
            end
        endcase

        out_cnt_d = (dec_step_d && (out_cnt_q != 16'hFFFF)) ? (out_cnt_q + 16'd1)
                                                            : out_cnt_q;
    end

    // State and registered-output flops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            k_q        <= 4'd0;
            dec_step_q <= 1'b0;
            code_pos_q <= 4'd0;
            code_len_q <= 3'd0;
            chardata_q <= 8'd0;
            done_q     <= 1'b0;
            out_cnt_q  <= 16'd0;
        end else begin
            state_q    <= state_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            k_q        <= k_d;
            dec_step_q <= dec_step_d;
            code_pos_q <= code_pos_d;
            code_len_q <= code_len_d;
            chardata_q <= chardata_d;
            done_q     <= done_d;
            out_cnt_q  <= out_cnt_d;
        end
    end

`ifdef LZ_CHECK_EN
    logic err_q, err_d;

    // A copy codeword is illegal if it points past the search buffer or
    // further back than the characters decoded so far (out_cnt_q at load time).
    always_comb begin
        err_d = err_q;
        if (w_start_new && (w_cand[10:8] != 3'd0) &&
            ((int'(w_cand[14:11]) >= SEARCH_LEN) ||
             ({12'd0, w_cand[14:11]} >= out_cnt_q))) begin
            err_d = 1'b1;
        end
    end

    // Sticky protocol error flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign dec_step = dec_step_q;
    assign code_pos = code_pos_q;
    assign code_len = code_len_q;
    assign chardata = chardata_q;
    assign done     = done_q;
    assign out_cnt  = out_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_lz77_code_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_lz77_code_scheduler
// Purpose  : Directed, table-driven bench for lz77_code_scheduler plus short
//            hand-written sequences for backpressure and the optional
//            LZ_CHECK_EN position check.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lz77_code_scheduler;

    logic        clk;
    logic        reset;
    logic        cw_valid;
    logic        cw_ready;
    logic [3:0]  cw_pos;
    logic [2:0]  cw_len;
    logic [7:0]  cw_char;
    logic        dec_step;
    logic [3:0]  code_pos;
    logic [2:0]  code_len;
    logic [7:0]  chardata;
    logic        done;
    logic [15:0] out_cnt;
    logic        err;

    int checks   = 0;
    int failures = 0;

    lz77_code_scheduler #(
        .FIFO_DEPTH (4),
        .SEARCH_LEN (9),
        .END_CHAR   (8'h24)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .cw_valid (cw_valid),
        .cw_ready (cw_ready),
        .cw_pos   (cw_pos),
        .cw_len   (cw_len),
        .cw_char  (cw_char),
        .dec_step (dec_step),
        .code_pos (code_pos),
        .code_len (code_len),
        .chardata (chardata),
        .done     (done),
        .out_cnt  (out_cnt),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        v;
        logic [3:0]  pos;
        logic [2:0]  len;
        logic [7:0]  ch;
        logic        e_rdy;
        logic        e_step;
        logic [3:0]  e_pos;
        logic [2:0]  e_len;
        logic [7:0]  e_ch;
        logic        e_done;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic r, input logic v, input logic [3:0] p,
                                input logic [2:0] l, input logic [7:0] c,
                                input logic erdy, input logic estep, input logic [3:0] ep,
                                input logic [2:0] el, input logic [7:0] ec,
                                input logic ed, input logic [15:0] en);
        vec_t t;
        t.rst_n = r;  t.v = v;  t.pos = p;  t.len = l;  t.ch = c;
        t.e_rdy = erdy; t.e_step = estep; t.e_pos = ep; t.e_len = el;
        t.e_ch = ec; t.e_done = ed; t.e_cnt = en;
        tbl.push_back(t);
    endfunction

    task automatic chk(input string nm, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s row=%0d got=%0h expected=%0h", nm, row, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0; cw_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic push_one(input logic [3:0] p, input logic [2:0] l, input logic [7:0] c);
        @(negedge clk);
        cw_valid = 1'b1; cw_pos = p; cw_len = l; cw_char = c;
        @(negedge clk);
        cw_valid = 1'b0;
    endtask

    int accepted;
    int accept5_cyc;
    int steps;
    int first_step;
    int last_step;
    logic rdy_c4;

    initial begin
        reset = 1'b0; cw_valid = 1'b0; cw_pos = '0; cw_len = '0; cw_char = '0;

        // rst v pos len ch | rdy step pos len ch done cnt
        // Literal stream a, b, $ then a refused push while done.
        add(0,0,0,0,8'h00, 1,0,0,0,8'h00,0,0);
        add(1,1,0,0,8'h61, 1,0,0,0,8'h00,0,0);
        add(1,1,0,0,8'h62, 1,1,0,0,8'h61,0,1);
        add(1,1,0,0,8'h24, 1,1,0,0,8'h62,0,2);
        add(1,0,0,0,8'h00, 1,1,0,0,8'h24,0,3);
        add(1,1,0,0,8'h6B, 0,0,0,0,8'h24,1,3);
        add(1,0,0,0,8'h00, 0,0,0,0,8'h24,1,3);
        // Copy codeword: literal x then (0,3,y) -> 4 steps of y.
        add(0,0,0,0,8'h00, 1,0,0,0,8'h00,0,0);
        add(1,1,0,0,8'h78, 1,0,0,0,8'h00,0,0);
        add(1,1,0,3,8'h79, 1,1,0,0,8'h78,0,1);
        add(1,0,0,0,8'h00, 1,1,0,3,8'h79,0,2);
        add(1,0,0,0,8'h00, 1,1,0,3,8'h79,0,3);
        add(1,0,0,0,8'h00, 1,1,0,3,8'h79,0,4);
        add(1,0,0,0,8'h00, 1,1,0,3,8'h79,0,5);
        add(1,0,0,0,8'h00, 1,0,0,3,8'h79,0,5);
        // Underflow gap of 5 idle cycles between two literals.
        add(0,0,0,0,8'h00, 1,0,0,0,8'h00,0,0);
        add(1,1,0,0,8'h67, 1,0,0,0,8'h00,0,0);
        add(1,0,0,0,8'h00, 1,1,0,0,8'h67,0,1);
        for (int i = 0; i < 4; i++) add(1,0,0,0,8'h00, 1,0,0,0,8'h67,0,1);
        add(1,1,0,0,8'h68, 1,0,0,0,8'h67,0,1);
        add(1,0,0,0,8'h00, 1,1,0,0,8'h68,0,2);
        add(1,0,0,0,8'h00, 1,0,0,0,8'h68,0,2);
        // Async reset during step 2 of a len=5 codeword, then a fresh literal.
        add(0,0,0,0,8'h00, 1,0,0,0,8'h00,0,0);
        add(1,1,2,5,8'h77, 1,0,0,0,8'h00,0,0);
        add(1,0,0,0,8'h00, 1,1,2,5,8'h77,0,1);
        add(1,0,0,0,8'h00, 1,1,2,5,8'h77,0,2);
        add(0,0,0,0,8'h00, 1,0,0,0,8'h00,0,0);
        add(1,1,0,0,8'h6E, 1,0,0,0,8'h00,0,0);
        add(1,0,0,0,8'h00, 1,1,0,0,8'h6E,0,1);
        add(1,0,0,0,8'h00, 1,0,0,0,8'h6E,0,1);

        foreach (tbl[i]) begin
            @(negedge clk);
            reset    = tbl[i].rst_n;
            cw_valid = tbl[i].v;
            cw_pos   = tbl[i].pos;
            cw_len   = tbl[i].len;
            cw_char  = tbl[i].ch;
            #1;
            chk("cw_ready", i, 32'(cw_ready), 32'(tbl[i].e_rdy));
            chk("dec_step", i, 32'(dec_step), 32'(tbl[i].e_step));
            chk("code_pos", i, 32'(code_pos), 32'(tbl[i].e_pos));
            chk("code_len", i, 32'(code_len), 32'(tbl[i].e_len));
            chk("chardata", i, 32'(chardata), 32'(tbl[i].e_ch));
            chk("done",     i, 32'(done),     32'(tbl[i].e_done));
            chk("out_cnt",  i, 32'(out_cnt),  32'(tbl[i].e_cnt));
`ifndef LZ_CHECK_EN
            chk("err_off",  i, 32'(err), 32'd0);
`endif
        end

        // Backpressure: five (1,7,z) words offered continuously.
        do_reset();
        accepted = 0; accept5_cyc = -1; steps = 0; first_step = -1; last_step = -1;
        rdy_c4 = 1'bx;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            cw_valid = (accepted < 5);
            cw_pos = 4'd1; cw_len = 3'd7; cw_char = 8'h7A;
            #1;
            if (c == 4) rdy_c4 = cw_ready;
            if (dec_step) begin
                steps++;
                if (first_step < 0) first_step = c;
                last_step = c;
            end
            if (cw_valid && cw_ready) begin
                accepted++;
                if (accepted == 5) accept5_cyc = c;
            end
        end
        cw_valid = 1'b0;
        chk("bp_ready_full",   0, 32'(rdy_c4), 32'd0);
        chk("bp_accepted",     0, 32'(accepted), 32'd5);
        chk("bp_accept5_cyc",  0, 32'(accept5_cyc), 32'd9);
        chk("bp_steps",        0, 32'(steps), 32'd40);
        chk("bp_first_step",   0, 32'(first_step), 32'd1);
        chk("bp_last_step",    0, 32'(last_step), 32'd40);
        chk("bp_out_cnt",      0, 32'(out_cnt), 32'd40);
        chk("bp_code_len",     0, 32'(code_len), 32'd7);
        chk("bp_chardata",     0, 32'(chardata), 32'h7A);
        chk("bp_done",         0, 32'(done), 32'd0);
`ifndef LZ_CHECK_EN
        chk("bp_err_off",      0, 32'(err), 32'd0);
`endif

`ifdef LZ_CHECK_EN
        // Copy before any history exists.
        do_reset();
        #1;
        chk("chk_err_reset", 0, 32'(err), 32'd0);
        push_one(4'd2, 3'd1, 8'h71);
        @(negedge clk); #1;
        chk("chk_err_nohist", 0, 32'(err), 32'd1);

        // Valid copy after 10 literals, then an out-of-window position.
        do_reset();
        #1;
        chk("chk_err_reset2", 0, 32'(err), 32'd0);
        for (int i = 0; i < 10; i++) push_one(4'd0, 3'd0, 8'h61);
        push_one(4'd3, 3'd2, 8'h72);
        repeat (4) @(negedge clk);
        #1;
        chk("chk_err_legal", 0, 32'(err), 32'd0);
        chk("chk_cnt_legal", 0, 32'(out_cnt), 32'd13);
        push_one(4'd9, 3'd1, 8'h71);
        repeat (2) @(negedge clk);
        #1;
        chk("chk_err_window", 0, 32'(err), 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
